gpu_rect_raster: RTL

GPU_RECT_RASTER -- requirements
Module: gpu_rect_raster

---
 rtl/gpu_pkg.sv | 13 +
 rtl/gpu_rect_clip.sv | 36 +++
 rtl/gpu_rect_raster.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: raster FSM states and default screen geometry.
package gpu_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rast_state_e;

endpackage

// File: rtl/gpu_rect_clip.sv
// Rectangle corner normalisation and clamping to the visible screen.
module gpu_rect_clip #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int XW       = $clog2(SCREEN_W),
  parameter int YW       = $clog2(SCREEN_H)
) (
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  input  logic [YW-1:0] y1,
  input  logic [YW-1:0] y2,
  output logic [XW-1:0] xmin,
  output logic [XW-1:0] xmax,
  output logic [YW-1:0] ymin,
  output logic [YW-1:0] ymax,
  output logic          empty
);

  localparam logic [XW-1:0] XLIM = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YLIM = YW'(SCREEN_H - 1);

  logic [XW-1:0] xhi;
  logic [YW-1:0] yhi;

  assign xmin = (x1 < x2) ? x1 : x2;
  assign xhi  = (x1 < x2) ? x2 : x1;
  assign ymin = (y1 < y2) ? y1 : y2;
  assign yhi  = (y1 < y2) ? y2 : y1;

  assign xmax = (xhi > XLIM) ? XLIM : xhi;
  assign ymax = (yhi > YLIM) ? YLIM : yhi;

  // Fully off-screen rectangles produce no pixels at all.
  assign empty = (xmin > XLIM) || (ymin > YLIM);

endmodule

// File: rtl/gpu_rect_raster.sv
// Axis-aligned rectangle rasteriser: solid or outline, row-major pixel stream.
module gpu_rect_raster
  import gpu_pkg::*;
#(
  parameter  int SCREEN_W = SCREEN_W_DEF,
  parameter  int SCREEN_H = SCREEN_H_DEF,
  localparam int XW       = $clog2(SCREEN_W),
  localparam int YW       = $clog2(SCREEN_H)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [XW-1:0] x1_i,
  input  logic [XW-1:0] x2_i,
  input  logic [YW-1:0] y1_i,
  input  logic [YW-1:0] y2_i,
  input  logic          mode_i,
  input  logic          abort_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          pix_last_o,
  output logic          busy_o,
  output logic          done_o
);

  rast_state_e   state_q, state_d;
  logic [XW-1:0] xmin_q, xmax_q, x_q, x_d;
  logic [YW-1:0] ymin_q, ymax_q, y_q, y_d;
  logic          mode_q;
  logic          load;

  logic [XW-1:0] c_xmin, c_xmax;
  logic [YW-1:0] c_ymin, c_ymax;
  logic          c_empty;

  gpu_rect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XW       (XW),
    .YW       (YW)
  ) u_clip (
    .x1    (x1_i),
    .x2    (x2_i),
    .y1    (y1_i),
    .y2    (y2_i),
    .xmin  (c_xmin),
    .xmax  (c_xmax),
    .ymin  (c_ymin),
    .ymax  (c_ymax),
    .empty (c_empty)
  );

  logic fire, last, wrap, jump, interior;

  assign cmd_ready_o = (state_q == IDLE);
  assign pix_valid_o = (state_q == RUN);
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign x_o         = x_q;
  assign y_o         = y_q;

  assign fire     = pix_valid_o & pix_ready_i;
  assign last     = (x_q == xmax_q) && (y_q == ymax_q);
  assign interior = (y_q != ymin_q) && (y_q != ymax_q);
  assign wrap     = (x_q == xmax_q) && !last;
  // Outline interior rows skip straight from the left edge to the right.
  assign jump     = mode_q && interior &&
                    (x_q == xmin_q) && (x_q != xmax_q);

  assign pix_last_o = pix_valid_o & last;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (c_empty) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            load    = 1'b1;
            x_d     = c_xmin;
            y_d     = c_ymin;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (fire) begin
          unique case (1'b1)
            last: state_d = DONE;
            wrap: begin
              x_d = xmin_q;
              y_d = y_q + YW'(1);
            end
            jump:    x_d = xmax_q;
            default: x_d = x_q + XW'(1);
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (load) begin
        xmin_q <= c_xmin;
        xmax_q <= c_xmax;
        ymin_q <= c_ymin;
        ymax_q <= c_ymax;
        mode_q <= mode_i;
      end
    end
  end

endmodule
